spi_flash_slave_asic: RTL and testbench

SPI_FLASH_SLAVE_ASIC -- requirements
Module: spi_flash_slave_asic

---
 rtl/spi_flash_slave_asic.sv | 216 +++++++++++++++++++++
 tb/tb_spi_flash_slave_asic.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_slave_asic.sv
// SPI-mode-0 serial flash slave: read (0x03), page program (0x02), WREN/WRDI.
// SPI pins are oversampled in clk; backing memory is a simple byte port.
//
// state  | meaning
// IDLE   | waiting for chip-select to fall
// CMD    | shifting in the 8-bit opcode
// ADDR   | shifting in the 24-bit address
// READ   | streaming memory bytes out on MISO
// WRITE  | collecting program bytes, writing when wel=1
// IGNORE | unsupported/finished opcode, wait for chip-select to rise
module spi_flash_slave_asic #(
  parameter int PAGE_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SPI_SCK,
  input  logic        SPI_SS,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO,
  output logic [23:0] mem_addr,
  output logic        mem_rd_req,
  input  logic [7:0]  mem_rd_data,
  output logic        mem_wr_en,
  output logic [7:0]  mem_wr_data,
  output logic        wel
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    READ   = 3'd3,
    WRITE  = 3'd4,
    IGNORE = 3'd5
  } state_t;

  localparam logic [PAGE_BITS-1:0] PAGE_ONE = {{(PAGE_BITS-1){1'b0}}, 1'b1};

  // [0],[1] form the synchronizer; [2] is the previous synchronized sample
  logic [2:0] sck_pipe;
  logic [2:0] ss_pipe;
  logic [1:0] mosi_pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_pipe  <= 3'b000;
      ss_pipe   <= 3'b111;
      mosi_pipe <= 2'b00;
    end else begin
      sck_pipe  <= {sck_pipe[1:0], SPI_SCK};
      ss_pipe   <= {ss_pipe[1:0], SPI_SS};
      mosi_pipe <= {mosi_pipe[0], SPI_MOSI};
    end
  end

  logic sck_rise, sck_fall, ss_rise, ss_fall, mosi_bit;

  assign sck_rise = sck_pipe[1] & ~sck_pipe[2];
  assign sck_fall = ~sck_pipe[1] & sck_pipe[2];
  assign ss_rise  = ss_pipe[1] & ~ss_pipe[2];
  assign ss_fall  = ~ss_pipe[1] & ss_pipe[2];
  assign mosi_bit = mosi_pipe[1];

  state_t      state;
  logic [4:0]  bit_cnt;
  logic [22:0] shift_in;
  logic [23:0] shift_next;
  logic [7:0]  tx_sr;
  logic        rd_pend;
  logic        is_read;
  logic        is_prog;

  assign shift_next = {shift_in, mosi_bit};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= 5'd0;
      shift_in    <= 23'd0;
      tx_sr       <= 8'd0;
      rd_pend     <= 1'b0;
      is_read     <= 1'b0;
      is_prog     <= 1'b0;
      SPI_MISO    <= 1'b0;
      mem_addr    <= 24'd0;
      mem_rd_req  <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= 8'd0;
      wel         <= 1'b0;
    end else begin
      mem_rd_req <= 1'b0;
      mem_wr_en  <= 1'b0;
      rd_pend    <= mem_rd_req;

      // program address advances inside the page once the write strobe is done
      if (mem_wr_en)
        mem_addr <= {mem_addr[23:PAGE_BITS], mem_addr[PAGE_BITS-1:0] + PAGE_ONE};

      if (rd_pend)
        tx_sr <= mem_rd_data;

      if (ss_rise) begin
        state    <= IDLE;
        bit_cnt  <= 5'd0;
        shift_in <= 23'd0;
        SPI_MISO <= 1'b0;
        rd_pend  <= 1'b0;
        is_read  <= 1'b0;
        is_prog  <= 1'b0;
        if (is_prog)
          wel <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            SPI_MISO <= 1'b0;
            if (ss_fall) begin
              state    <= CMD;
              bit_cnt  <= 5'd0;
              shift_in <= 23'd0;
              is_read  <= 1'b0;
              is_prog  <= 1'b0;
            end
          end

          CMD: begin
            if (sck_rise) begin
              shift_in <= shift_next[22:0];
              if (bit_cnt == 5'd7) begin
                bit_cnt <= 5'd0;
                case (shift_next[7:0])
                  8'h03: begin
                    state   <= ADDR;
                    is_read <= 1'b1;
                  end
                  8'h02: begin
                    state   <= ADDR;
                    is_prog <= 1'b1;
                  end
                  8'h06: begin
                    state <= IGNORE;
                    wel   <= 1'b1;
                  end
                  8'h04: begin
                    state <= IGNORE;
                    wel   <= 1'b0;
                  end
                  default: state <= IGNORE;
                endcase
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          ADDR: begin
            if (sck_rise) begin
              shift_in <= shift_next[22:0];
              if (bit_cnt == 5'd23) begin
                bit_cnt  <= 5'd0;
                mem_addr <= shift_next;
                if (is_read) begin
                  state      <= READ;
                  mem_rd_req <= 1'b1;
                end else begin
                  state <= WRITE;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          READ: begin
            if (sck_fall) begin
              SPI_MISO <= tx_sr[7];
              tx_sr    <= {tx_sr[6:0], 1'b0};
            end else if (sck_rise) begin
              // prefetch the next byte so its MSB is ready for the coming fall
              if (bit_cnt == 5'd7) begin
                bit_cnt    <= 5'd0;
                mem_addr   <= mem_addr + 24'd1;
                mem_rd_req <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          WRITE: begin
            SPI_MISO <= 1'b0;
            if (sck_rise) begin
              shift_in <= shift_next[22:0];
              if (bit_cnt == 5'd7) begin
                bit_cnt <= 5'd0;
                if (wel) begin
                  mem_wr_en   <= 1'b1;
                  mem_wr_data <= shift_next[7:0];
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          IGNORE: SPI_MISO <= 1'b0;

          default: begin
            state    <= IDLE;
            SPI_MISO <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_slave_asic.sv
// Directed bench for spi_flash_slave_asic: a mode-0 SPI master driven from
// tasks, a small byte memory model, and logs of every memory strobe.
module tb_spi_flash_slave_asic;

  localparam int HALF = 6;

  logic        clk;
  logic        reset;
  logic        SPI_SCK;
  logic        SPI_SS;
  logic        SPI_MOSI;
  logic        SPI_MISO;
  logic [23:0] mem_addr;
  logic        mem_rd_req;
  logic [7:0]  mem_rd_data;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_data;
  logic        wel;

  int checks;
  int errors;
  int viol;

  logic [23:0] rd_q[$];
  logic [23:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];

  spi_flash_slave_asic #(.PAGE_BITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .SPI_SCK     (SPI_SCK),
    .SPI_SS      (SPI_SS),
    .SPI_MOSI    (SPI_MOSI),
    .SPI_MISO    (SPI_MISO),
    .mem_addr    (mem_addr),
    .mem_rd_req  (mem_rd_req),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .wel         (wel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_lookup(input logic [23:0] a);
    case (a)
      24'h000100: return 8'hA5;
      24'h000101: return 8'h3C;
      24'hFFFFFF: return 8'h5A;
      24'h000000: return 8'hC3;
      default:    return 8'hEE;
    endcase
  endfunction

  // read data valid the cycle after the request
  always @(posedge clk)
    if (mem_rd_req) mem_rd_data <= mem_lookup(mem_addr);

  always @(negedge clk) begin
    if (mem_rd_req && mem_wr_en) viol++;
    if ((mem_rd_req || mem_wr_en) && SPI_SS) viol++;
    if (mem_rd_req) rd_q.push_back(mem_addr);
    if (mem_wr_en) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wr_data);
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input int n, input logic [7:0] tx, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      SPI_MOSI = tx[7-i];
      clk_wait(HALF);
      rx = {rx[6:0], SPI_MISO};
      SPI_SCK = 1'b1;
      clk_wait(HALF);
      SPI_SCK = 1'b0;
    end
  endtask

  task automatic ss_start();
    SPI_SS = 1'b0;
    clk_wait(HALF);
  endtask

  task automatic ss_end();
    clk_wait(HALF);
    SPI_SS = 1'b1;
    clk_wait(8);
  endtask

  task automatic send_cmd_addr(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] d;
    spi_bits(8, cmd, d);
    spi_bits(8, a[23:16], d);
    spi_bits(8, a[15:8], d);
    spi_bits(8, a[7:0], d);
  endtask

  task automatic single_cmd(input logic [7:0] cmd);
    logic [7:0] d;
    ss_start();
    spi_bits(8, cmd, d);
    ss_end();
  endtask

  task automatic clear_logs();
    rd_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clk_wait(3);
    checks++; if (SPI_MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", SPI_MISO); end
    checks++; if (wel !== 1'b0) begin errors++; $display("FAIL reset_wel got %b exp 0", wel); end
    checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req got %b exp 0", mem_rd_req); end
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", mem_wr_en); end
    checks++; if (mem_addr !== 24'h0) begin errors++; $display("FAIL reset_addr got %h exp 000000", mem_addr); end
    checks++; if (mem_wr_data !== 8'h0) begin errors++; $display("FAIL reset_wr_data got %h exp 00", mem_wr_data); end
    reset = 1'b1;
    clk_wait(4);
  endtask

  task automatic test_read();
    logic [7:0] rx1, rx7, d;
    logic       last;
    int         rd_at_end;
    clear_logs();
    ss_start();
    send_cmd_addr(8'h03, 24'h000100);
    spi_bits(8, 8'h00, rx1);
    spi_bits(7, 8'h00, rx7);
    SPI_MOSI = 1'b0;
    clk_wait(HALF);
    last = SPI_MISO;
    rd_at_end = rd_q.size();
    SPI_SCK = 1'b1;
    clk_wait(HALF);
    SPI_SCK = 1'b0;
    ss_end();
    d = {rx7[6:0], last};
    checks++; if (rx1 !== 8'hA5) begin errors++; $display("FAIL read_byte0 got %h exp a5", rx1); end
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL read_byte1 got %h exp 3c", d); end
    checks++; if (rd_at_end !== 2) begin errors++; $display("FAIL read_req_count got %0d exp 2", rd_at_end); end
    if (rd_q.size() >= 2) begin
      checks++; if (rd_q[0] !== 24'h000100) begin errors++; $display("FAIL read_addr0 got %h exp 000100", rd_q[0]); end
      checks++; if (rd_q[1] !== 24'h000101) begin errors++; $display("FAIL read_addr1 got %h exp 000101", rd_q[1]); end
    end
  endtask

  task automatic test_wrap_read();
    logic [7:0] rx1, rx2;
    clear_logs();
    ss_start();
    send_cmd_addr(8'h03, 24'hFFFFFF);
    spi_bits(8, 8'h00, rx1);
    spi_bits(8, 8'h00, rx2);
    ss_end();
    checks++; if (rx1 !== 8'h5A) begin errors++; $display("FAIL wrap_byte0 got %h exp 5a", rx1); end
    checks++; if (rx2 !== 8'hC3) begin errors++; $display("FAIL wrap_byte1 got %h exp c3", rx2); end
    checks++;
    if (rd_q.size() < 2) begin
      errors++; $display("FAIL wrap_req_count got %0d exp >=2", rd_q.size());
    end else if (rd_q[1] !== 24'h000000) begin
      errors++; $display("FAIL wrap_addr1 got %h exp 000000", rd_q[1]);
    end
  endtask

  task automatic test_program();
    logic [7:0] d;
    clear_logs();
    single_cmd(8'h06);
    checks++; if (wel !== 1'b1) begin errors++; $display("FAIL prog_wel_set got %b exp 1", wel); end
    ss_start();
    send_cmd_addr(8'h02, 24'h0012FF);
    spi_bits(8, 8'h11, d);
    spi_bits(8, 8'h22, d);
    ss_end();
    checks++;
    if (wr_addr_q.size() !== 2) begin
      errors++; $display("FAIL prog_write_count got %0d exp 2", wr_addr_q.size());
    end else begin
      if (wr_addr_q[0] !== 24'h0012FF) begin errors++; $display("FAIL prog_addr0 got %h exp 0012ff", wr_addr_q[0]); end
      checks++; if (wr_data_q[0] !== 8'h11) begin errors++; $display("FAIL prog_data0 got %h exp 11", wr_data_q[0]); end
      checks++; if (wr_addr_q[1] !== 24'h001200) begin errors++; $display("FAIL prog_addr1 got %h exp 001200", wr_addr_q[1]); end
      checks++; if (wr_data_q[1] !== 8'h22) begin errors++; $display("FAIL prog_data1 got %h exp 22", wr_data_q[1]); end
    end
    checks++; if (wel !== 1'b0) begin errors++; $display("FAIL prog_wel_clear got %b exp 0", wel); end
  endtask

  task automatic test_protected();
    logic [7:0] d;
    clear_logs();
    ss_start();
    send_cmd_addr(8'h02, 24'h000000);
    spi_bits(8, 8'h55, d);
    ss_end();
    checks++; if (wr_addr_q.size() !== 0) begin errors++; $display("FAIL protect_writes got %0d exp 0", wr_addr_q.size()); end
    checks++; if (wel !== 1'b0) begin errors++; $display("FAIL protect_wel got %b exp 0", wel); end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    clear_logs();
    single_cmd(8'h06);
    ss_start();
    send_cmd_addr(8'h02, 24'h000010);
    spi_bits(4, 8'hA0, d);
    ss_end();
    checks++; if (wr_addr_q.size() !== 0) begin errors++; $display("FAIL abort_writes got %0d exp 0", wr_addr_q.size()); end
    checks++; if (dut.state !== 3'd0) begin errors++; $display("FAIL abort_state got %0d exp 0", dut.state); end
    checks++; if (SPI_MISO !== 1'b0) begin errors++; $display("FAIL abort_miso got %b exp 0", SPI_MISO); end
    checks++; if (wel !== 1'b0) begin errors++; $display("FAIL abort_wel got %b exp 0", wel); end
  endtask

  task automatic test_wrdi_ignore();
    logic [7:0] d;
    clear_logs();
    single_cmd(8'h06);
    single_cmd(8'h04);
    checks++; if (wel !== 1'b0) begin errors++; $display("FAIL wrdi_wel got %b exp 0", wel); end
    ss_start();
    spi_bits(8, 8'h9F, d);
    spi_bits(8, 8'hFF, d);
    ss_end();
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL ignore_miso got %h exp 00", d); end
    checks++; if (rd_q.size() !== 0) begin errors++; $display("FAIL ignore_reads got %0d exp 0", rd_q.size()); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d;
    clear_logs();
    ss_start();
    send_cmd_addr(8'h03, 24'h000100);
    spi_bits(4, 8'h00, d);
    reset = 1'b0;
    #1;
    checks++; if (mem_addr !== 24'h0) begin errors++; $display("FAIL rst_mid_addr got %h exp 000000", mem_addr); end
    checks++; if (SPI_MISO !== 1'b0) begin errors++; $display("FAIL rst_mid_miso got %b exp 0", SPI_MISO); end
    checks++; if (mem_wr_data !== 8'h0) begin errors++; $display("FAIL rst_mid_wr_data got %h exp 00", mem_wr_data); end
    checks++; if (mem_rd_req !== 1'b0 || mem_wr_en !== 1'b0 || wel !== 1'b0) begin
      errors++; $display("FAIL rst_mid_strobes got rd=%b wr=%b wel=%b exp 0 0 0", mem_rd_req, mem_wr_en, wel);
    end
    SPI_SS = 1'b1;
    clk_wait(4);
    reset = 1'b1;
    clk_wait(4);
    ss_start();
    send_cmd_addr(8'h03, 24'h000100);
    spi_bits(8, 8'h00, d);
    ss_end();
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL rst_next_read got %h exp a5", d); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    viol        = 0;
    reset       = 1'b0;
    SPI_SCK     = 1'b0;
    SPI_SS      = 1'b1;
    SPI_MOSI    = 1'b0;
    mem_rd_data = 8'h00;
    test_reset();
    test_read();
    test_wrap_read();
    test_program();
    test_protected();
    test_abort();
    test_wrdi_ignore();
    test_reset_mid_read();
    checks++; if (viol !== 0) begin errors++; $display("FAIL strobe_exclusive got %0d exp 0", viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
